adder_err_eval: RTL and testbench
=================================

# adder_err_eval

Sequential error-evaluation monitor that consumes the outputs of a 16-bit approximate adder (17-bit sum) together with the operands that produced them. It recomputes the exact sum and accumulates error statistics over a fixed-length run. It sits downstream of the approximate adder netlists on the evaluation bench/FPGA harness and is the consumer of their result interface.

## Interface
- W, 16, operand width; sum width is W+1
- SAMPLES, 1024, number of operand/sum handshakes per run (≥1)
- ACC_W, 48, width of the absolute-error accumulator
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- in_valid  input  1  op_a/op_b/approx_sum valid this cycle
- in_ready  output  1  block accepts a sample this cycle
- op_a  input  W  adder operand A
- op_b  input  W  adder operand B
- approx_sum  input  W+1  approximate adder result (bit W = carry-out)
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE; results stable
- err_count  output  32  samples with non-zero error
- max_abs_err  output  W+1  largest |exact − approx|
- sum_abs_err  output  ACC_W  Σ|exact − approx|, saturating
- err_bitmask  output  W+1  OR of (exact XOR approx) over the run

## Operation
- States: IDLE → RUN → DRAIN → DONE → (start) RUN.
- IDLE/DONE + start=1: clear err_count, max_abs_err, sum_abs_err, err_bitmask and sample counter; go to RUN. start is ignored in RUN/DRAIN.
- RUN: in_ready=1. A handshake is in_valid & in_ready. The sample counter increments per handshake. On the SAMPLES-th handshake, go to DRAIN; in_ready=0 from the next cycle.
- Stage 1, on the handshake edge: exact = op_a + op_b (W+1 bits, zero-extended). diff = exact − approx_sum as (W+2)-bit signed. The registered abs = |diff| (fits in W+1 bits). Also register nz = (diff≠0), the xor mask, and s1_valid.
- Stage 2, on the edge after s1_valid: err_count += nz; max_abs_err = max(max, abs); sum_abs_err += abs, clamped at all-ones; err_bitmask |= mask.
- DRAIN: lasts exactly 2 cycles, then DONE. Outputs hold in DONE until the next start.
- Statistics outputs are registered and always driven. They are meaningful only when done=1.

## Timing
- Reset values: state=IDLE; in_ready, busy, done = 0; all statistics = 0; pipeline valids = 0.
- in_ready is a function of state only (registered), not of in_valid.
- Last handshake at edge N: stage 1 at N, accumulate at N+1, state=DONE after edge N+2. done rises in the cycle following edge N+2.
- Minimum run length is SAMPLES+3 cycles from the start edge.
- start held high in DONE restarts every cycle it is seen in DONE. The clear and the RUN entry occur on the same edge.
- rst_n low at any time, including mid-run or mid-drain, returns to reset values asynchronously. Partial statistics are discarded.
- Sample counter width is $clog2(SAMPLES+1). There is no wrap within a run.

## Configuration
- ADDER_ERR_EVAL_BITMASK_EN defined: the XOR mask pipeline and the err_bitmask accumulation are built.
- Not defined: the mask logic is omitted and err_bitmask is tied to 0. All other behaviour and timing are unchanged.

## Structure
- Shared package adder_eval_pkg holds the state enum (IDLE, RUN, DRAIN, DONE), the default W, SAMPLES and ACC_W constants, and a saturating-add helper function.
- One sub-module, adder_err_diff: combinational exact-sum, signed diff, abs and xor mask. It is instantiated once, feeding stage 1.

## Test plan
- Reset: hold rst_n=0, then release → state IDLE, in_ready=0, done=0, all statistics 0. in_valid=1 in IDLE → nothing counted.
- Exact run (SAMPLES=4): four samples of op_a=0x1234, op_b=0x0001, approx=0x01235 → done; err_count=0, max_abs_err=0, sum_abs_err=0, err_bitmask=0.
- Mixed errors (SAMPLES=4):
  - (0x0003, 0x0004, approx 0x00000) → abs 7
  - (0x00FF, 0x0001, approx 0x00100) → abs 0
  - (0x0080, 0x0000, approx 0x00000) → abs 0x80
  - (0x0000, 0x0000, approx 0x00005) → abs 5
  - Required result: err_count=3, max_abs_err=0x80, sum_abs_err=140, err_bitmask=0x00087 with the macro, 0 without.
- Carry edge: op_a=0xFFFF, op_b=0xFFFF, approx=0x00000 → abs 0x1FFFE; max_abs_err=0x1FFFE.
- Backpressure: in_valid toggled 1,0,0,1,… → only handshakes are counted; done asserts exactly 3 cycles after the 4th handshake edge; start pulsed mid-RUN is ignored.
- Reset mid-run: rst_n=0 after 2 of 4 samples → immediate IDLE and zeroed outputs. A fresh start plus 4 exact samples yields err_count=0.

Source files
------------

// File: rtl/adder_eval_pkg.sv
// Shared types and defaults for the approximate-adder error monitor.
// Holds the run FSM encoding and the saturating accumulator helper.
package adder_eval_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_SAMPLES = 1024;
  localparam int DEF_ACC_W   = 48;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Add two values held in the low w bits, clamping at w-bit all-ones.
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int unsigned w
  );
    logic [64:0] s;
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s   = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[63:0];
  endfunction

endpackage

// File: rtl/adder_err_diff.sv
// Exact sum, signed error magnitude and error bit mask for one sample.
// Mask output exists only with ADDER_ERR_EVAL_BITMASK_EN.
module adder_err_diff
  import adder_eval_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  input  logic [W:0]   approx_i,
  output logic [W:0]   abs_o,
`ifdef ADDER_ERR_EVAL_BITMASK_EN
  output logic [W:0]   mask_o,
`endif
  output logic         nz_o
);

  logic [W:0]   exact;
  logic [W+1:0] diff;

  assign exact = {1'b0, op_a_i} + {1'b0, op_b_i};
  assign diff  = {1'b0, exact} - {1'b0, approx_i};

  // |diff| < 2^(W+1), so negating the low W+1 bits is exact.
  assign abs_o = diff[W+1] ? (~diff[W:0] + (W+1)'(1))
                           : diff[W:0];
  assign nz_o  = |diff;

`ifdef ADDER_ERR_EVAL_BITMASK_EN
  assign mask_o = exact ^ approx_i;
`endif

endmodule

// File: rtl/adder_err_eval.sv
// Run-based error statistics monitor for a W-bit approximate adder.
// Optional err_bitmask tracking: define ADDER_ERR_EVAL_BITMASK_EN.
module adder_err_eval
  import adder_eval_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int SAMPLES = DEF_SAMPLES,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [31:0]      err_count,
  output logic [W:0]       max_abs_err,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       err_bitmask
);

  localparam int CW = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);

  state_e          state_q;
  logic            in_ready_q, busy_q, done_q;
  logic            drain_q;
  logic [CW-1:0]   cnt_q;
  logic            s1_valid_q, nz_q;
  logic [W:0]      abs_q;
  logic [31:0]     err_cnt_q, err_cnt_d;
  logic [W:0]      max_q, max_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic            hs;
  logic [W:0]      abs_c;
  logic            nz_c;

`ifdef ADDER_ERR_EVAL_BITMASK_EN
  logic [W:0] mask_c, mask_q, bm_q, bm_d;
`endif

  adder_err_diff #(.W(W)) u_diff (
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .approx_i (approx_sum),
    .abs_o    (abs_c),
`ifdef ADDER_ERR_EVAL_BITMASK_EN
    .mask_o   (mask_c),
`endif
    .nz_o     (nz_c)
  );

  assign hs = in_valid & in_ready_q;

  always_comb begin
    err_cnt_d = err_cnt_q + 32'(nz_q);
    max_d     = (abs_q > max_q) ? abs_q : max_q;
    sum_d     = ACC_W'(sat_add(64'(sum_q), 64'(abs_q), ACC_W));
`ifdef ADDER_ERR_EVAL_BITMASK_EN
    bm_d      = bm_q | mask_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= 1'b0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      nz_q       <= 1'b0;
      abs_q      <= '0;
      err_cnt_q  <= '0;
      max_q      <= '0;
      sum_q      <= '0;
`ifdef ADDER_ERR_EVAL_BITMASK_EN
      mask_q     <= '0;
      bm_q       <= '0;
`endif
    end else begin
      s1_valid_q <= hs;
      if (hs) begin
        abs_q  <= abs_c;
        nz_q   <= nz_c;
`ifdef ADDER_ERR_EVAL_BITMASK_EN
        mask_q <= mask_c;
`endif
      end
      if (s1_valid_q) begin
        err_cnt_q <= err_cnt_d;
        max_q     <= max_d;
        sum_q     <= sum_d;
`ifdef ADDER_ERR_EVAL_BITMASK_EN
        bm_q      <= bm_d;
`endif
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            max_q      <= '0;
            sum_q      <= '0;
`ifdef ADDER_ERR_EVAL_BITMASK_EN
            bm_q       <= '0;
`endif
          end
        end
        RUN: begin
          if (hs) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              drain_q    <= 1'b0;
            end
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_cnt_q;
  assign max_abs_err = max_q;
  assign sum_abs_err = sum_q;
`ifdef ADDER_ERR_EVAL_BITMASK_EN
  assign err_bitmask = bm_q;
`else
  assign err_bitmask = '0;
`endif

endmodule

// File: tb/tb_adder_err_eval.sv
// Randomized bench for adder_err_eval with an arithmetic reference model.
// Runs with SAMPLES=4; mask expectations follow ADDER_ERR_EVAL_BITMASK_EN.
module tb_adder_err_eval;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int AW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [W:0]    approx_sum = '0;
  logic          busy, done;
  logic [31:0]   err_count;
  logic [W:0]    max_abs_err;
  logic [AW-1:0] sum_abs_err;
  logic [W:0]    err_bitmask;

  adder_err_eval #(.W(W), .SAMPLES(S), .ACC_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .max_abs_err (max_abs_err),
    .sum_abs_err (sum_abs_err),
    .err_bitmask (err_bitmask)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] va [S];
  logic [W-1:0] vb [S];
  logic [W:0]   vs [S];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_smp(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W:0] s);
    va[i] = a;
    vb[i] = b;
    vs[i] = s;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":cnt"}, 64'(err_count), 0);
    chk({tag, ":max"}, 64'(max_abs_err), 0);
    chk({tag, ":sum"}, 64'(sum_abs_err), 0);
    chk({tag, ":msk"}, 64'(err_bitmask), 0);
  endtask

  // One full run; bp=1 adds random in_valid gaps and stray start pulses.
  task automatic run(input string tag, input bit bp);
    longint cnt = 0, mx = 0, sm = 0, mk = 0;
    longint ex, d, ab;
    int idx = 0, cyc = 0;
    bit v, rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":rdy0"}, 64'(in_ready), 1);
    chk({tag, ":busy0"}, 64'(busy), 1);
    chk({tag, ":done0"}, 64'(done), 0);
    chk({tag, ":clr"}, 64'(err_count), 0);
    while (idx < S && cyc < 200) begin
      v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid   = v;
      op_a       = va[idx];
      op_b       = vb[idx];
      approx_sum = vs[idx];
      start      = bp ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy = in_ready;
      tick();
      cyc++;
      if (v && rdy) begin
        ex = longint'(va[idx]) + longint'(vb[idx]);
        d  = ex - longint'(vs[idx]);
        ab = (d < 0) ? -d : d;
        if (d != 0) cnt++;
        if (ab > mx) mx = ab;
        sm += ab;
        mk |= ex ^ longint'(vs[idx]);
        idx++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
`ifndef ADDER_ERR_EVAL_BITMASK_EN
    mk = 0;
`endif
    chk({tag, ":hs"}, 64'(idx), 64'(S));
    chk({tag, ":rdyN"}, 64'(in_ready), 0);
    chk({tag, ":busyN"}, 64'(busy), 1);
    chk({tag, ":doneN"}, 64'(done), 0);
    tick();
    chk({tag, ":doneN1"}, 64'(done), 0);
    tick();
    chk({tag, ":doneN2"}, 64'(done), 1);
    chk({tag, ":busyN2"}, 64'(busy), 0);
    chk({tag, ":cnt"}, 64'(err_count), 64'(cnt));
    chk({tag, ":max"}, 64'(max_abs_err), 64'(mx));
    chk({tag, ":sum"}, 64'(sum_abs_err), 64'(sm));
    chk({tag, ":msk"}, 64'(err_bitmask), 64'(mk));
  endtask

  task automatic load_exact();
    for (int i = 0; i < S; i++) set_smp(i, 16'h1234, 16'h0001, 17'h01235);
  endtask

  task automatic load_mixed();
    set_smp(0, 16'h0003, 16'h0004, 17'h00000);
    set_smp(1, 16'h00FF, 16'h0001, 17'h00100);
    set_smp(2, 16'h0080, 16'h0000, 17'h00000);
    set_smp(3, 16'h0000, 16'h0000, 17'h00005);
  endtask

  initial begin
    logic [W:0] ex;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    chk("rst:rdy", 64'(in_ready), 0);
    chk("rst:busy", 64'(busy), 0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    op_a = 16'h0003;
    op_b = 16'h0004;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("idle:rdy", 64'(in_ready), 0);
    chk("idle:busy", 64'(busy), 0);
    chk("idle:done", 64'(done), 0);
    check_zero("idle");

    load_exact();
    run("exact", 1'b0);
    load_mixed();
    run("mixed", 1'b0);
    chk("mixed:max80", 64'(max_abs_err), 64'h80);
    chk("mixed:sum140", 64'(sum_abs_err), 64'd140);

    for (int i = 0; i < S; i++) set_smp(i, 16'hFFFF, 16'hFFFF, 17'h00000);
    run("carry", 1'b0);
    chk("carry:max", 64'(max_abs_err), 64'h1FFFE);

    load_mixed();
    run("bp", 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < S; i++) begin
        va[i] = W'($urandom);
        vb[i] = W'($urandom);
        ex    = {1'b0, va[i]} + {1'b0, vb[i]};
        vs[i] = ($urandom_range(0, 2) == 0) ? ex
              : ($urandom_range(0, 1) == 0) ? (W+1)'($urandom)
              : ex ^ (W+1)'($urandom_range(0, 255));
      end
      run($sformatf("rnd%0d", r), r[0]);
    end

    load_mixed();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    op_a = va[0]; op_b = vb[0]; approx_sum = vs[0];
    tick();
    op_a = va[1]; op_b = vb[1]; approx_sum = vs[1];
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid:cnt1", 64'(err_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid");
    chk("mid:rdy", 64'(in_ready), 0);
    chk("mid:busy", 64'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    load_exact();
    run("post", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
